// File: rtl/gn_axis_pkg.sv
// Shared helpers for the gn_axis width converters (upsizer and downsizer).
package gn_axis_pkg;

    localparam int unsigned GN_AXIS_DEF_RATIO = 4;

    // Lane counter type for the default 8-to-32 configuration.
    typedef logic [$clog2(GN_AXIS_DEF_RATIO)-1:0] gn_axis_cnt_t;

    function automatic int unsigned gn_axis_ratio(input int unsigned m, input int unsigned s);
        return (s == 0) ? 0 : m / s;
    endfunction

    function automatic int unsigned gn_axis_keep_w(input int unsigned m, input int unsigned s);
        return gn_axis_ratio(m, s);
    endfunction

    function automatic int unsigned gn_axis_cnt_w(input int unsigned r);
        return (r < 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/gn_axis_out_stage.sv
// Wide AXI4-Stream output register: load, hold-while-stalled, clear on handshake.
// Optional keep/last sideband when GN_AXIS_UPSIZER_TLAST_EN is defined.
module gn_axis_out_stage
    import gn_axis_pkg::*;
#(
    parameter int unsigned Width = 32
`ifdef GN_AXIS_UPSIZER_TLAST_EN
    ,
    parameter int unsigned KeepW = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] ld_data_i,
`ifdef GN_AXIS_UPSIZER_TLAST_EN
    input  logic [KeepW-1:0] ld_keep_i,
    input  logic             ld_last_i,
    output logic [KeepW-1:0] keep_o,
    output logic             last_o,
`endif
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
`ifdef GN_AXIS_UPSIZER_TLAST_EN
    logic [KeepW-1:0] keep_q, keep_d;
    logic             last_q, last_d;
`endif

    // A load in the same cycle as an output handshake replaces the word back-to-back.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef GN_AXIS_UPSIZER_TLAST_EN
        keep_d  = keep_q;
        last_d  = last_q;
`endif
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = ld_data_i;
`ifdef GN_AXIS_UPSIZER_TLAST_EN
            keep_d  = ld_keep_i;
            last_d  = ld_last_i;
`endif
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef GN_AXIS_UPSIZER_TLAST_EN
            keep_q  <= '0;
            last_q  <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef GN_AXIS_UPSIZER_TLAST_EN
            keep_q  <= keep_d;
            last_q  <= last_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
`ifdef GN_AXIS_UPSIZER_TLAST_EN
    assign keep_o  = keep_q;
    assign last_o  = last_q;
`endif

endmodule

// File: rtl/gn_axis_upsizer.sv
// AXI4-Stream narrow-to-wide packer, first beat in lane 0.
// Define GN_AXIS_UPSIZER_TLAST_EN for tlast/tkeep support (short final words).
module gn_axis_upsizer
    import gn_axis_pkg::*;
#(
    parameter int unsigned P_S_AXIS_DWIDTH = 8,
    parameter int unsigned P_M_AXIS_DWIDTH = 32
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [P_S_AXIS_DWIDTH-1:0]                        s_axis_tdata,
    input  logic                                              s_axis_tvalid,
    output logic                                              s_axis_tready,
`ifdef GN_AXIS_UPSIZER_TLAST_EN
    input  logic                                              s_axis_tlast,
    output logic [gn_axis_keep_w(P_M_AXIS_DWIDTH, P_S_AXIS_DWIDTH)-1:0] m_axis_tkeep,
    output logic                                              m_axis_tlast,
`endif
    output logic [P_M_AXIS_DWIDTH-1:0]                        m_axis_tdata,
    output logic                                              m_axis_tvalid,
    input  logic                                              m_axis_tready
);

    localparam int unsigned S    = P_S_AXIS_DWIDTH;
    localparam int unsigned R    = gn_axis_ratio(P_M_AXIS_DWIDTH, P_S_AXIS_DWIDTH);
    localparam int unsigned CntW = gn_axis_cnt_w(R);
    localparam int unsigned AccW = (R < 2) ? S : S * (R - 1);

    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntMax = cnt_t'(R - 1);

    if ((S == 0) || (R < 2) || (R * S != P_M_AXIS_DWIDTH)) begin : g_param_check
        $fatal(1, "gn_axis_upsizer: master width must be an integer multiple >= 2 of slave width");
    end

    cnt_t                       cnt_q, cnt_d;
    logic [AccW-1:0]            acc_q, acc_d;
    logic [P_M_AXIS_DWIDTH-1:0] word;
    logic                       s_hs;
    logic                       complete;

    assign s_hs = s_axis_tvalid && s_axis_tready;

`ifdef GN_AXIS_UPSIZER_TLAST_EN
    logic [R-1:0] keep;

    // Any beat may complete a word, so the lane count cannot gate ready.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign complete      = s_hs && ((cnt_q == CntMax) || s_axis_tlast);
`else
    assign s_axis_tready = (cnt_q != CntMax) || !m_axis_tvalid || m_axis_tready;
    assign complete      = s_hs && (cnt_q == CntMax);
`endif

    // Lanes above the completing beat are zero-filled so stale accumulator data never leaks.
    for (genvar i = 0; i < R; i++) begin : g_lane
        if (i < R - 1) begin : g_acc
            assign word[i*S +: S] = (cnt_q > cnt_t'(i))  ? acc_q[i*S +: S] :
                                    (cnt_q == cnt_t'(i)) ? s_axis_tdata    : '0;
        end else begin : g_top
            assign word[i*S +: S] = (cnt_q == CntMax) ? s_axis_tdata : '0;
        end
`ifdef GN_AXIS_UPSIZER_TLAST_EN
        assign keep[i] = (cnt_q >= cnt_t'(i));
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (s_hs) begin
            if (complete) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
                acc_d[int'(cnt_q)*S +: S] = s_axis_tdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    gn_axis_out_stage #(
        .Width     (P_M_AXIS_DWIDTH)
`ifdef GN_AXIS_UPSIZER_TLAST_EN
        ,
        .KeepW     (R)
`endif
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .load_i    (complete),
        .ld_data_i (word),
`ifdef GN_AXIS_UPSIZER_TLAST_EN
        .ld_keep_i (keep),
        .ld_last_i (s_axis_tlast),
        .keep_o    (m_axis_tkeep),
        .last_o    (m_axis_tlast),
`endif
        .ready_i   (m_axis_tready),
        .valid_o   (m_axis_tvalid),
        .data_o    (m_axis_tdata)
    );

endmodule

// File: tb/tb_gn_axis_upsizer.sv
// Directed-vector and scoreboard bench for gn_axis_upsizer (8-to-32).
module tb_gn_axis_upsizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
`ifdef GN_AXIS_UPSIZER_TLAST_EN
    logic        s_axis_tlast;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
`endif

    always #5 clk = ~clk;

    gn_axis_upsizer #(
        .P_S_AXIS_DWIDTH (8),
        .P_M_AXIS_DWIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
`ifdef GN_AXIS_UPSIZER_TLAST_EN
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
`endif
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct {
        logic        rst;
        logic        sv;
        logic [7:0]  sd;
        logic        mr;
        logic        esr;
        logic        emv;
        logic [31:0] emd;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    function automatic void add(input logic rst, input logic sv, input logic [7:0] sd,
                                input logic mr, input logic esr, input logic emv,
                                input logic [31:0] emd);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sd = sd; v.mr = mr;
        v.esr = esr; v.emv = emv; v.emd = emd;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] b1(input logic x);
        return {31'b0, x};
    endfunction

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] part;
        logic [31:0] expw;
        logic [31:0] prev_md;
        logic [7:0]  bb;
        int          nparts;
        int          b;
        int          got;
        int          last_cyc;
        int          sent;
        logic        pending;
        logic        prev_stall;

        // rst sv  sd     mr  esr emv emd
        add(0, 1, 8'h11, 1, 1, 0, 32'h0);
        add(0, 1, 8'h22, 1, 1, 0, 32'h0);
        add(0, 1, 8'h33, 1, 1, 0, 32'h0);
        add(0, 1, 8'h44, 1, 1, 0, 32'h0);
        add(0, 0, 8'h00, 1, 1, 1, 32'h44332211);
        add(0, 0, 8'h00, 1, 1, 0, 32'h44332211);
        // Output stalled while eight bytes are offered.
        add(0, 1, 8'h00, 0, 1, 0, 32'h44332211);
        add(0, 1, 8'h01, 0, 1, 0, 32'h44332211);
        add(0, 1, 8'h02, 0, 1, 0, 32'h44332211);
        add(0, 1, 8'h03, 0, 1, 0, 32'h44332211);
        add(0, 1, 8'h04, 0, 1, 1, 32'h03020100);
        add(0, 1, 8'h05, 0, 1, 1, 32'h03020100);
        add(0, 1, 8'h06, 0, 1, 1, 32'h03020100);
        add(0, 1, 8'h07, 0, 0, 1, 32'h03020100);
        add(0, 1, 8'h07, 0, 0, 1, 32'h03020100);
        add(0, 1, 8'h07, 1, 1, 1, 32'h03020100);
        add(0, 0, 8'h00, 1, 1, 1, 32'h07060504);
        add(0, 0, 8'h00, 1, 1, 0, 32'h07060504);
        // Reset mid-word discards 0xAA/0xBB.
        add(0, 1, 8'hAA, 1, 1, 0, 32'h07060504);
        add(0, 1, 8'hBB, 1, 1, 0, 32'h07060504);
        add(1, 0, 8'h00, 1, 1, 0, 32'h07060504);
        add(0, 1, 8'h01, 1, 1, 0, 32'h0);
        add(0, 1, 8'h02, 1, 1, 0, 32'h0);
        add(0, 1, 8'h03, 1, 1, 0, 32'h0);
        add(0, 1, 8'h04, 1, 1, 0, 32'h0);
        add(0, 0, 8'h00, 1, 1, 1, 32'h04030201);
        add(0, 0, 8'h00, 1, 1, 0, 32'h04030201);

        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = 8'h00;
        m_axis_tready = 1'b0;
`ifdef GN_AXIS_UPSIZER_TLAST_EN
        s_axis_tlast = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset tvalid", b1(m_axis_tvalid), 32'h0);
        check("reset tdata", m_axis_tdata, 32'h0);
        check("reset tready", b1(s_axis_tready), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            s_axis_tvalid = vecs[i].sv;
            s_axis_tdata = vecs[i].sd;
            m_axis_tready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d s_tready", i), b1(s_axis_tready), b1(vecs[i].esr));
            check($sformatf("vec%0d m_tvalid", i), b1(m_axis_tvalid), b1(vecs[i].emv));
            check($sformatf("vec%0d m_tdata", i), m_axis_tdata, vecs[i].emd);
        end

        // 64 continuous bytes, ready high: one word every 4 cycles, no bubbles.
        b = 0;
        got = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
            @(negedge clk);
            m_axis_tready = 1'b1;
            s_axis_tvalid = (b < 64);
            s_axis_tdata = 8'(b);
            #1;
            if (b < 64) begin
                check($sformatf("stream s_tready byte %0d", b), b1(s_axis_tready), 32'h1);
                if (s_axis_tready) b++;
            end
            if (m_axis_tvalid) begin
                bb = 8'(4 * got);
                expw = {bb + 8'd3, bb + 8'd2, bb + 8'd1, bb};
                check($sformatf("stream word %0d", got), m_axis_tdata, expw);
                if (got > 0) check($sformatf("stream gap %0d", got), 32'(cyc - last_cyc), 32'd4);
                last_cyc = cyc;
                got++;
            end
        end
        check("stream word count", 32'(got), 32'd16);

`ifdef GN_AXIS_UPSIZER_TLAST_EN
        // Short word closed by tlast, then a full word.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 8'(8'h10 * (i + 1));
            s_axis_tlast = (i == 2);
            #1;
            check("tlast s_tready", b1(s_axis_tready), 32'h1);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        #1;
        check("tlast m_tvalid", b1(m_axis_tvalid), 32'h1);
        check("tlast m_tdata", m_axis_tdata, 32'h00302010);
        check("tlast m_tkeep", {28'b0, m_axis_tkeep}, 32'h7);
        check("tlast m_tlast", b1(m_axis_tlast), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 8'(i + 1);
            #1;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        #1;
        check("full m_tvalid", b1(m_axis_tvalid), 32'h1);
        check("full m_tdata", m_axis_tdata, 32'h04030201);
        check("full m_tkeep", {28'b0, m_axis_tkeep}, 32'hF);
        check("full m_tlast", b1(m_axis_tlast), 32'h0);
`endif

        // Random valid/ready at 30 % duty against a reference queue.
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        got = 0;
        sent = 0;
        nparts = 0;
        part = '0;
        pending = 1'b0;
        prev_stall = 1'b0;
        prev_md = '0;
        for (int cyc = 0; cyc < 60000 && got < 2500; cyc++) begin
            @(negedge clk);
            if (!pending) begin
                s_axis_tvalid = (sent < 10000) && ($urandom_range(0, 99) < 30);
                s_axis_tdata = 8'($urandom);
            end
            m_axis_tready = ($urandom_range(0, 99) < 30);
            #1;
            if (prev_stall) begin
                check("hold tvalid", b1(m_axis_tvalid), 32'h1);
                check("hold tdata", m_axis_tdata, prev_md);
            end
            pending = s_axis_tvalid && !s_axis_tready;
            if (s_axis_tvalid && s_axis_tready) begin
                part = {s_axis_tdata, part[31:8]};
                nparts++;
                sent++;
                if (nparts == 4) begin
                    exp_q.push_back(part);
                    nparts = 0;
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("random spurious word", m_axis_tdata, 32'hDEADBEEF);
                    if (m_axis_tdata === 32'hDEADBEEF) $display("FAIL random spurious word");
                end else begin
                    check($sformatf("random word %0d", got), m_axis_tdata, exp_q.pop_front());
                end
                got++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_md = m_axis_tdata;
        end
        check("random word count", 32'(got), 32'd2500);
        check("random bytes sent", 32'(sent), 32'd10000);

        @(negedge clk);
        s_axis_tvalid = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gn_axis_upsizer.md
# gn_axis_upsizer

AXI4-Stream narrow-to-wide width converter: accepts P_S_AXIS_DWIDTH-bit beats on its slave port and packs consecutive beats, first beat in the least-significant lane, into one P_M_AXIS_DWIDTH-bit beat on its master port. It is the inverse of the team's 32-to-8 downsizer. It sits on the receive path after a byte-wide source and in front of 32-bit consumers, and can be chained behind the downsizer for loopback benches.

## Interface
- P_S_AXIS_DWIDTH, 8, slave data width; must be at least 1.
- P_M_AXIS_DWIDTH, 32, master data width; must be an integer multiple of P_S_AXIS_DWIDTH.
- Derived R = P_M_AXIS_DWIDTH / P_S_AXIS_DWIDTH; R must be at least 2, otherwise elaboration fails with $fatal.
- clk  input  1  single clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- s_axis_tdata  input  P_S_AXIS_DWIDTH  narrow input data.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready.
- s_axis_tlast  input  1  end of packet; present only with GN_AXIS_UPSIZER_TLAST_EN.
- m_axis_tdata  output  P_M_AXIS_DWIDTH  packed output data.
- m_axis_tvalid  output  1  output valid.
- m_axis_tready  input  1  output ready.
- m_axis_tkeep  output  R  lane-valid mask; present only with GN_AXIS_UPSIZER_TLAST_EN.
- m_axis_tlast  output  1  end of packet; present only with GN_AXIS_UPSIZER_TLAST_EN.

## Operation
- Lane counter `cnt` runs 0..R-1. The accumulator holds lanes 0..R-2. The output register holds one wide word and its valid flag.
- An input handshake (s_axis_tvalid && s_axis_tready) at cnt < R-1 writes lane `cnt` and increments `cnt`.
- An input handshake at cnt == R-1 is the completing beat:
  - loads the output register with {s_axis_tdata, accumulator lanes R-2..0};
  - sets m_axis_tvalid;
  - sets cnt to 0.
- An output handshake clears m_axis_tvalid unless the same cycle loads a new word.
- The output register is stable while m_axis_tvalid && !m_axis_tready; this is the AXI hold rule.
- The ready rule is registered-state only and never depends on s_axis_tvalid:
  - s_axis_tready = (cnt != R-1) || !m_axis_tvalid || m_axis_tready.
- A narrow beat is never dropped or duplicated. A wide beat carries exactly R consecutive accepted narrow beats.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, cnt=0, accumulator=0, m_axis_tkeep=0, m_axis_tlast=0. s_axis_tready is 1 one cycle after reset deasserts.
- Reset asserted mid-word discards the partial accumulator and any pending output word, with no flush.

## Timing
- Latency: m_axis_tvalid rises on the clock edge that samples the completing input handshake, so it is visible one cycle after that handshake.
- Throughput with m_axis_tready held high:
  - one narrow beat per cycle;
  - one wide beat every R cycles;
  - no bubbles.
- If the output is stalled and a completing beat is pending, s_axis_tready drops in the cycle where cnt == R-1. It rises in the cycle m_axis_tready returns. Output handshake and completing input in the same cycle replace the word back-to-back.
- No combinational path from s_axis_* to m_axis_*. The only combinational path to s_axis_tready is from m_axis_tready.

## Configuration
- GN_AXIS_UPSIZER_TLAST_EN defined:
  - adds s_axis_tlast, m_axis_tkeep and m_axis_tlast;
  - an accepted beat with s_axis_tlast=1 at cnt=k is a completing beat;
  - it emits lanes 0..k, with upper lanes zero-filled;
  - it sets m_axis_tkeep = (1<<(k+1))-1 and m_axis_tlast=1, and sets cnt to 0;
  - a full word completed without tlast has tkeep all ones and tlast=0;
  - ready becomes s_axis_tready = !m_axis_tvalid || m_axis_tready, because any beat may complete a word.
- GN_AXIS_UPSIZER_TLAST_EN undefined: those ports are absent and only full words are produced.

## Structure
- Package gn_axis_pkg:
  - function gn_axis_ratio(m,s) returning m/s;
  - localparam-style keep-width helper;
  - typedef for the lane counter sized $clog2(R).
- The package is shared with the downsizer.
- One sub-module, gn_axis_out_stage: a wide output register with valid/hold/load logic and optional keep/last, parameterized by width.

## Test plan
- Reset, then s bytes 0x11,0x22,0x33,0x44 with m_axis_tready=1 -> m_axis_tdata=0x44332211, m_axis_tvalid high for exactly 1 cycle, 1 cycle after the 4th handshake.
- 64 continuous bytes 0x00..0x3F with m_axis_tready=1 -> 16 words 0x03020100..0x3F3E3D3C, s_axis_tready never low, one word every 4 cycles.
- m_axis_tready=0 while 8 bytes are offered -> first word held stable, s_axis_tready low at cnt=3 of the second word, no loss when ready is released; output 0x03020100 then 0x07060504.
- Reset pulsed after 2 bytes (0xAA,0xBB), then 0x01..0x04 -> single output 0x04030201, no trace of 0xAA/0xBB.
- With TLAST_EN: bytes 0x10,0x20,0x30 with tlast on 0x30 -> tdata=0x00302010, tkeep=0x7, tlast=1; next 4 bytes form a full word with tkeep=0xF.
- Random valid/ready at 30 % duty over 10 000 bytes, checked by a reference queue scoreboard -> zero mismatches, no AXI hold-rule violations.
